force_override_bank: RTL

- Multi-channel, parametrised force/release override stage for the forceable-signal regression suite.
- Each channel registers a driven value, then presents it on an observation bus.
- Per-bit masked force values can replace the driven value, either permanently or for a programmed number of cycles.
- Sits between the stimulus counter logic and the checker; commands arrive on a valid/ready port.

---
 rtl/force_override_bank.sv | 138 +++++++++++++
 1 files changed

// File: rtl/force_override_bank.sv
// Multi-channel force/release override stage: registered per-channel data with masked,
// optionally timed, force values. Define FORCE_OVR_DEPOSIT_EN to enable the op-3 DEPOSIT command.
module force_override_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned TIMER_W  = 8,
  parameter int unsigned CYC_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [3:0]                cmd_chan,
  input  logic [WIDTH-1:0]          cmd_mask,
  input  logic [WIDTH-1:0]          cmd_value,
  input  logic [TIMER_W-1:0]        cmd_dur,
  output logic [CHANNELS*WIDTH-1:0] obs,
  output logic [CHANNELS-1:0]       forced,
  output logic                      err,
  output logic [CYC_W-1:0]          cyc
);

  typedef enum logic [1:0] {
    OpForce      = 2'd0,
    OpRelease    = 2'd1,
    OpForceTimed = 2'd2,
    OpDeposit    = 2'd3
  } op_e;

  logic               ready_q;
  logic               err_q, err_d;
  logic [CYC_W-1:0]   cyc_q;
  logic [WIDTH-1:0]   stage_q [CHANNELS];
  logic [WIDTH-1:0]   stage_d [CHANNELS];
  logic [WIDTH-1:0]   mask_q  [CHANNELS];
  logic [WIDTH-1:0]   mask_d  [CHANNELS];
  logic [WIDTH-1:0]   fval_q  [CHANNELS];
  logic [WIDTH-1:0]   fval_d  [CHANNELS];
  logic [TIMER_W-1:0] timer_q [CHANNELS];
  logic [TIMER_W-1:0] timer_d [CHANNELS];
  logic [CHANNELS-1:0] hit;
  logic               accept;
  logic               chan_ok;

  assign cmd_ready = ready_q;
  assign err       = err_q;
  assign cyc       = cyc_q;
  assign accept    = cmd_valid & ready_q;
  assign chan_ok   = 32'(cmd_chan) < CHANNELS;

  always_comb begin
    hit = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      hit[k] = accept && chan_ok && (32'(cmd_chan) == 32'(k));
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept && !chan_ok) err_d = 1'b1;
`ifndef FORCE_OVR_DEPOSIT_EN
    if (accept && (op_e'(cmd_op) == OpDeposit)) err_d = 1'b1;
`endif
    for (int k = 0; k < int'(CHANNELS); k++) begin
      stage_d[k] = data_in[k*WIDTH +: WIDTH];
      mask_d[k]  = mask_q[k];
      fval_d[k]  = fval_q[k];
      timer_d[k] = timer_q[k];
      // Timer countdown; an accepted command below overrides this expiry.
      if (timer_q[k] == TIMER_W'(1)) begin
        mask_d[k]  = '0;
        timer_d[k] = '0;
      end else if (timer_q[k] != '0) begin
        timer_d[k] = timer_q[k] - TIMER_W'(1);
      end
      if (hit[k]) begin
        unique case (op_e'(cmd_op))
          OpForce: begin
            mask_d[k]  = mask_q[k] | cmd_mask;
            fval_d[k]  = (fval_q[k] & ~cmd_mask) | (cmd_value & cmd_mask);
            timer_d[k] = '0;
          end
          OpForceTimed: begin
            mask_d[k]  = mask_q[k] | cmd_mask;
            fval_d[k]  = (fval_q[k] & ~cmd_mask) | (cmd_value & cmd_mask);
            timer_d[k] = cmd_dur;
          end
          OpRelease: begin
            mask_d[k] = mask_q[k] & ~cmd_mask;
            if (mask_d[k] == '0) timer_d[k] = '0;
          end
          OpDeposit: begin
`ifdef FORCE_OVR_DEPOSIT_EN
            stage_d[k] = (data_in[k*WIDTH +: WIDTH] & ~cmd_mask) | (cmd_value & cmd_mask);
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
      for (int k = 0; k < int'(CHANNELS); k++) begin
        stage_q[k] <= '0;
        mask_q[k]  <= '0;
        fval_q[k]  <= '0;
        timer_q[k] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      err_q   <= err_d;
      cyc_q   <= cyc_q + CYC_W'(1);
      for (int k = 0; k < int'(CHANNELS); k++) begin
        stage_q[k] <= stage_d[k];
        mask_q[k]  <= mask_d[k];
        fval_q[k]  <= fval_d[k];
        timer_q[k] <= timer_d[k];
      end
    end
  end

  always_comb begin
    obs    = '0;
    forced = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      obs[k*WIDTH +: WIDTH] = (stage_q[k] & ~mask_q[k]) | (fval_q[k] & mask_q[k]);
      forced[k]             = |mask_q[k];
    end
  end

endmodule
